fm_period_decoder: RTL and testbench

FM_PERIOD_DECODER -- requirements
Module: fm_period_decoder

---
 rtl/fm_period_decoder.sv | 115 +++++++++++
 tb/tb_fm_period_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fm_period_decoder.sv
// Receive-side FM PWM decoder: recovers per-frame duty samples, tracks mid-scale
// crossings with hysteresis and reports the sine period in frames.
module fm_period_decoder #(
  parameter int unsigned MAX_COUNT    = 128,
  parameter int unsigned HYST         = 8,
  parameter int unsigned PERIOD_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          pwm_in,
  output logic [$clog2(MAX_COUNT):0]    sample,
  output logic                          sample_valid,
  output logic [PERIOD_WIDTH-1:0]       period,
  output logic                          period_valid,
  output logic                          overflow
);

  localparam int unsigned CW = $clog2(MAX_COUNT);
  localparam logic [CW-1:0] FRAME_LAST = '1;
  localparam logic [CW:0] HI_TH = (CW+1)'(MAX_COUNT / 2 + HYST);
  localparam logic [CW:0] LO_TH = (CW+1)'(MAX_COUNT / 2 - HYST);
  localparam logic [PERIOD_WIDTH-1:0] PMAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  logic                    pwm_meta, pwm_s;
  logic [CW-1:0]           frame_cnt;
  logic [CW:0]             acc;
  logic [CW:0]             sample_q;
  logic                    sample_valid_q;
  state_t                  state, state_next;
  logic                    rise;
  logic                    armed;
  logic [PERIOD_WIDTH-1:0] frames_since;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                    overflow_q;
  logic                    period_valid_q;

  // Only LOW->HIGH is a rising crossing; IDLE->HIGH merely establishes the level.
  always_comb begin
    state_next = state;
    rise       = 1'b0;
    if (sample_valid_q) begin
      case (state)
        S_IDLE: begin
          if (sample_q >= HI_TH)      state_next = S_HIGH;
          else if (sample_q <= LO_TH) state_next = S_LOW;
        end
        S_LOW: begin
          if (sample_q >= HI_TH) begin
            state_next = S_HIGH;
            rise       = 1'b1;
          end
        end
        S_HIGH: begin
          if (sample_q <= LO_TH) state_next = S_LOW;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_meta       <= 1'b0;
      pwm_s          <= 1'b0;
      frame_cnt      <= '0;
      acc            <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      state          <= S_IDLE;
      armed          <= 1'b0;
      frames_since   <= '0;
      period_q       <= '0;
      overflow_q     <= 1'b0;
      period_valid_q <= 1'b0;
    end else if (enable) begin
      pwm_meta  <= pwm_in;
      pwm_s     <= pwm_meta;
      frame_cnt <= frame_cnt + CW'(1);
      if (frame_cnt == FRAME_LAST) begin
        sample_q       <= acc + (CW+1)'(pwm_s);
        sample_valid_q <= 1'b1;
        acc            <= '0;
      end else begin
        acc            <= acc + (CW+1)'(pwm_s);
        sample_valid_q <= 1'b0;
      end
      state          <= state_next;
      period_valid_q <= 1'b0;
      if (sample_valid_q) begin
        if (rise) begin
          frames_since <= '0;
          armed        <= 1'b1;
          if (armed) begin
            period_q       <= (frames_since == PMAX) ? PMAX : frames_since + PERIOD_WIDTH'(1);
            overflow_q     <= (frames_since == PMAX);
            period_valid_q <= 1'b1;
          end
        end else if (frames_since != PMAX) begin
          frames_since <= frames_since + PERIOD_WIDTH'(1);
        end
      end
    end
  end

  // Pulses are held while disabled and appear on the next enabled cycle.
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q & enable;
  assign period       = period_q;
  assign period_valid = period_valid_q & enable;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_fm_period_decoder.sv
// Randomized bench for fm_period_decoder: two instances (16- and 8-bit period)
// checked every cycle against a frame-level reference model.
module tb_fm_period_decoder;

  localparam int M   = 128;
  localparam int HY  = 8;
  localparam int PWA = 16;
  localparam int PWB = 8;
  localparam int HI  = M / 2 + HY;
  localparam int LO  = M / 2 - HY;

  logic clk = 1'b0;
  logic reset, enable, pwm_in;
  logic [7:0]     sample_a, sample_b;
  logic           sv_a, sv_b, pv_a, pv_b, ovf_a, ovf_b;
  logic [PWA-1:0] period_a;
  logic [PWB-1:0] period_b;

  always #5 clk = ~clk;

  fm_period_decoder #(.MAX_COUNT(M), .HYST(HY), .PERIOD_WIDTH(PWA)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .sample(sample_a), .sample_valid(sv_a), .period(period_a),
    .period_valid(pv_a), .overflow(ovf_a)
  );

  fm_period_decoder #(.MAX_COUNT(M), .HYST(HY), .PERIOD_WIDTH(PWB)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .sample(sample_b), .sample_valid(sv_b), .period(period_b),
    .period_valid(pv_b), .overflow(ovf_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pwm history per enabled cycle, frame sums, crossing frame indices.
  bit hist[$];
  int n, f_pend, level, last_cross;
  bit sv_pend, pv_pend;
  int exp_sample, exp_per_a, exp_ovf_a, exp_per_b, exp_ovf_b;

  function automatic void model_reset();
    hist.delete();
    n = 0; f_pend = 0; level = 0; last_cross = -1;
    sv_pend = 0; pv_pend = 0;
    exp_sample = 0; exp_per_a = 0; exp_ovf_a = 0; exp_per_b = 0; exp_ovf_b = 0;
  endfunction

  function automatic void gap_to_period(input int gap, input int pw, output int per,
                                        output int ovf);
    int mx, fs;
    mx  = (1 << pw) - 1;
    fs  = gap - 1;
    if (fs > mx) fs = mx;
    ovf = (fs == mx);
    per = (fs == mx) ? mx : fs + 1;
  endfunction

  function automatic void model_edge(input bit p);
    bit new_pv, rising;
    int sum;
    new_pv = 0;
    if (sv_pend) begin
      rising = 0;
      case (level)
        0: if (exp_sample >= HI) level = 2; else if (exp_sample <= LO) level = 1;
        1: if (exp_sample >= HI) begin level = 2; rising = 1; end
        default: if (exp_sample <= LO) level = 1;
      endcase
      if (rising) begin
        if (last_cross >= 0) begin
          gap_to_period(f_pend - last_cross, PWA, exp_per_a, exp_ovf_a);
          gap_to_period(f_pend - last_cross, PWB, exp_per_b, exp_ovf_b);
          new_pv = 1;
        end
        last_cross = f_pend;
      end
    end
    pv_pend = new_pv;
    hist.push_back(p);
    if (n % M == M - 1) begin
      sum = 0;
      for (int i = n - M + 1; i <= n; i++) if (i - 2 >= 0) sum += int'(hist[i-2]);
      exp_sample = sum;
      f_pend     = n / M;
      sv_pend    = 1;
    end else begin
      sv_pend = 0;
    end
    n++;
  endfunction

  task automatic tick(input bit p, input bit en, input bit rst);
    @(negedge clk);
    check_val("sample_valid_a", sv_a, sv_pend & enable);
    check_val("sample_valid_b", sv_b, sv_pend & enable);
    check_val("period_valid_a", pv_a, pv_pend & enable);
    check_val("period_valid_b", pv_b, pv_pend & enable);
    check_val("sample_a", sample_a, exp_sample);
    check_val("sample_b", sample_b, exp_sample);
    check_val("period_a", period_a, exp_per_a);
    check_val("overflow_a", ovf_a, exp_ovf_a);
    check_val("period_b", period_b, exp_per_b);
    check_val("overflow_b", ovf_b, exp_ovf_b);
    reset  = rst;
    enable = en;
    pwm_in = p;
    @(posedge clk);
    if (rst) model_reset();
    else if (en) model_edge(p);
  endtask

  task automatic run_cycles(input int duty, input int cnt);
    repeat (cnt) tick(bit'((n % M) < duty), 1'b1, 1'b0);
  endtask

  task automatic run_frames(input int base, input int k, input bit jit);
    int d;
    repeat (k) begin
      d = jit ? base + int'($urandom_range(0, 6)) - 3 : base;
      run_cycles(d, M);
    end
  endtask

  // Enable dropped for 50 cycles at a random point (including the pulse cycle).
  task automatic frame_with_gap(input int duty);
    int s;
    s = int'($urandom_range(0, M - 1));
    run_cycles(duty, s);
    repeat (50) tick(bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    run_cycles(duty, M - s);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check_val("reset_sample", sample_a, 0);
    check_val("reset_period", period_a, 0);
    check_val("reset_valid", {sv_a, pv_a, ovf_a}, 0);

    // Constant high: full-scale samples, no period.
    run_frames(M, 10, 1'b0);
    #1 check_val("full_scale_sample", sample_a, M);

    // 16/16 square pattern: period 32.
    repeat (4) begin
      run_frames(100, 16, 1'b1);
      run_frames(28, 16, 1'b1);
    end
    #1 check_val("square_period", period_a, 32);
    check_val("square_overflow", ovf_a, 0);

    // In-band samples after LOW hold state.
    run_frames(28, 2, 1'b0);
    run_frames(62, 1, 1'b0);
    run_frames(66, 1, 1'b0);
    run_frames(62, 1, 1'b0);
    run_frames(66, 1, 1'b0);
    #1 check_val("hyst_period_held", period_a, 32);

    // 300-frame gap saturates the 8-bit instance.
    run_frames(100, 16, 1'b1);
    run_frames(28, 284, 1'b1);
    run_frames(100, 16, 1'b1);
    #1 check_val("sat_period_b", period_b, 255);
    check_val("sat_overflow_b", ovf_b, 1);
    check_val("wide_period_a", period_a, 300);
    run_frames(28, 16, 1'b1);
    run_frames(100, 16, 1'b1);
    #1 check_val("post_sat_period_b", period_b, 32);
    check_val("post_sat_overflow_b", ovf_b, 0);

    // Reset mid-period (enable low, reset must still win).
    run_cycles(28, 5 * M + 37);
    repeat (3) tick(1'b1, 1'b0, 1'b1);
    #1 check_val("mid_reset_period", period_a, 0);
    check_val("mid_reset_sample", sample_a, 0);
    run_frames(28, 16, 1'b1);
    run_frames(100, 16, 1'b1);
    run_frames(28, 16, 1'b1);
    #1 check_val("one_crossing_no_period", period_a, 0);

    // Enable gaps inside the running pattern.
    repeat (4) frame_with_gap(100 + int'($urandom_range(0, 6)) - 3);
    run_frames(100, 12, 1'b1);
    repeat (3) frame_with_gap(28 + int'($urandom_range(0, 6)) - 3);
    run_frames(28, 13, 1'b1);
    run_frames(100, 2, 1'b1);
    #1 check_val("gap_period", period_a, 32);
    check_val("gap_overflow", ovf_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
